// File: rtl/regfile_pkg.sv
// Shared types for the two-requester register file.
// Holds the FSM state type and the requester count.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// Grant is combinational on req and is one-hot or zero.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  logic r_prio;

  always_comb begin
    grant = '0;
    if (req[0] & (~req[1] | ~r_prio)) begin
      grant[0] = 1'b1;
    end else if (req[1]) begin
      grant[1] = 1'b1;
    end
  end

  // Winner drops to low priority; pointer only moves on a real transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (advance & (|grant)) begin
      r_prio <= grant[0];
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Single-port register array shared by two valid/ready requesters.
// Zero-fills on reset, then serves one round-robin access per cycle.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  rf_state_t               r_state;
  logic [ADDR_WIDTH-1:0]   r_init_cnt;
  logic                    r_init_done;
  logic [NUM_REQ-1:0]      r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [NUM_REQ-1:0]      w_grant;
  logic                    w_fire;
  logic                    w_idx;
  logic                    w_write;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (r_init_done),
    .grant   (w_grant)
  );

  assign req_ready = w_grant & {NUM_REQ{r_init_done}};
  assign w_fire    = |req_ready;
  assign w_idx     = req_ready[1];
  assign w_write   = w_idx ? req_write[1] : req_write[0];
  assign w_addr    = w_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                           : req_addr[ADDR_WIDTH-1:0];
  assign w_wdata   = w_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                           : req_wdata[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= INIT;
      r_init_cnt   <= '0;
      r_init_done  <= 1'b0;
      r_resp_valid <= '0;
      r_resp_rdata <= '0;
    end else begin
      unique case (r_state)
        INIT: begin
          r_init_cnt   <= r_init_cnt + 1'b1;
          r_resp_valid <= '0;
          r_resp_rdata <= '0;
          if (r_init_cnt == LAST) begin
            r_state     <= RUN;
            r_init_done <= 1'b1;
          end
        end
        RUN: begin
          r_resp_valid <= req_ready;
          r_resp_rdata <= (w_fire & ~w_write) ? r_mem[w_addr] : '0;
        end
        default: begin
          r_state <= INIT;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_mem[r_init_cnt] <= '0;
    end else if (w_fire & w_write & ~rst) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign init_done  = r_init_done;

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares one single-port register array (one access per cycle) between two requesters using valid/ready handshakes and round-robin arbitration.
- After every reset it runs an init sequence that zeroes all entries before accepting any request.
- Read and write completions come back as a registered response, one cycle after the request is accepted.
- Sits between two datapath clients (e.g. a sequencer and a debug port) and the shared storage.

Parameters:
- DATA_WIDTH, 8, width of each register entry.
- ADDR_WIDTH, 2, address width; DEPTH = 2**ADDR_WIDTH entries.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_write  in  2  per-requester op: 1 = write, 0 = read.
- req_addr  in  2*ADDR_WIDTH  requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  2*DATA_WIDTH  requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  2  grant; transfer on requester i when req_valid[i] & req_ready[i].
- resp_valid  out  2  one-cycle completion pulse per requester.
- resp_rdata  out  DATA_WIDTH  read data for the requester flagged in resp_valid; 0 for write completions.
- init_done  out  1  high once zero-fill completes.

Behaviour:
- Reset values:
  - req_ready=0, resp_valid=0, resp_rdata=0, init_done=0.
  - Priority pointer prio=0, FSM=INIT, init counter=0.
- FSM INIT:
  - Each cycle writes 0 to entry[init_cnt], then increments init_cnt.
  - On the cycle entry DEPTH-1 is written, move to RUN.
  - init_done goes high on the first RUN cycle, i.e. exactly DEPTH cycles after rst deasserts.
  - req_ready stays 0 throughout INIT.
- FSM RUN (stays there until rst):
  - req_ready is combinational: init_done & grant[i]; it may depend on req_valid.
  - If only one requester is valid, it is granted.
  - If both are valid, requester prio is granted.
  - After any grant, prio <= ~granted index. With no grant, prio is held.
  - At most one transfer per cycle; the loser must hold its request, and it is granted next cycle.
- Accepted write (cycle N): entry[addr] <= wdata at the posedge ending cycle N.
- Accepted read (cycle N): samples entry[addr] as it stands during N and registers it into resp_rdata.
  - A write accepted in cycle N-1 is visible to this read.
  - Reads of an address being zeroed are impossible, since ready=0 in INIT.
- Response timing:
  - resp_valid[g] = 1 in cycle N+1 for the granted requester g; the other bit is 0.
  - resp_rdata holds the read data for reads and 0 for writes.
  - No backpressure on responses; the consumer must accept.
  - Back-to-back accepts produce back-to-back response pulses.
- Address width is exact, so every address is in range; no wrap handling is needed.
- rst asserted mid-operation:
  - The next cycle is INIT and all contents are rezeroed.
  - Any response due in that cycle is suppressed: resp_valid=0.
- Unselected slices of req_addr/req_wdata are don't-care.

Decomposition:
- Shared package regfile_pkg:
  - typedef enum {INIT, RUN} rf_state_t.
  - localparam NUM_REQ = 2.
- Sub-module rr_arbiter2, purely a 2-way round-robin arbiter:
  - Inputs: clk, rst, req[1:0], advance.
  - Outputs: grant[1:0], one-hot or zero.
  - Holds the prio flop.
- Storage array, init counter and response register live in regfile_arbiter.

Test Plan:
- Init: rst high 2 cycles, then low → init_done rises exactly 4 cycles later (DEPTH=4) with req_ready=00 until then; then read addr 2 from requester 0 → resp_valid=01 next cycle, resp_rdata=0x00.
- Write then read: requester 0 writes 0xFF to addr 0, then reads addr 0 next cycle → write resp_valid=01 with rdata 0x00, then resp_valid=01 with rdata 0xFF.
- Contention: prio=0, requester 0 writes 0xEE to addr 1 while requester 1 reads addr 1 in the same cycle → requester 0 granted first; requester 1 granted the following cycle and gets resp_rdata=0xEE.
- Fairness: both requesters continuously valid for 6 cycles → grant sequence 0,1,0,1,0,1 and resp_valid alternates 01,10,... with no idle cycles.
- Single requester streaming: requester 1 alone valid for 4 cycles, reading addrs 0..3 after writing 0xFF/0xEE/0xDD/0xCC → granted every cycle, rdata FF,EE,DD,CC.
- Reset mid-run: assert rst during an accepted read → no resp_valid, init_done=0 for 4 cycles, then a read of addr 0 returns 0x00.
